// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame geometry and
// the bit-period divisor used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Bit period in clock cycles, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers and a
// registered occupancy count; a pop frees its slot for a push on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop   = rd_en && !empty;
  assign w_push  = wr_en && (!full || w_pop);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign count   = r_count;

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are serialized
// LSB first on a registered TxD, back-to-back with no idle gap.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          TxD,
  output logic                          TxD_busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam int IW  = $clog2(DATA_BITS);

  tx_state_e            r_state;
  tx_state_e            w_state_next;
  logic [CW-1:0]        r_baud;
  logic [CW-1:0]        w_baud_next;
  logic [IW-1:0]        r_bit_idx;
  logic [IW-1:0]        w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_txd;
  logic                 w_txd_next;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_bit_end;
  logic [7:0]           w_fifo_data;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_fifo_data),
    .full    (full),
    .empty   (w_empty),
    .count   (count)
  );

  assign w_bit_end = (r_baud == CW'(DIV - 1));
  assign TxD       = r_txd;
  assign TxD_busy  = (r_state != IDLE) || (count != '0);

  // State, timing and line registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_txd     <= w_txd_next;
      if (w_pop) r_shift <= w_fifo_data;
    end
  end

  // Next-state, bit index and pop decisions; STOP chains straight into START.
  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = START;
        end else begin
          w_state_next = IDLE;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next   = DATA;
          w_bit_idx_next = '0;
        end else begin
          w_state_next = START;
        end
      end
      DATA: begin
        if (w_bit_end && (r_bit_idx == IW'(DATA_BITS - 1))) begin
          w_state_next = STOP;
        end else if (w_bit_end) begin
          w_bit_idx_next = r_bit_idx + IW'(1);
        end else begin
          w_state_next = DATA;
        end
      end
      STOP: begin
        if (w_bit_end && !w_empty) begin
          w_pop        = 1'b1;
          w_state_next = START;
        end else if (w_bit_end) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = STOP;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if ((r_state == IDLE) || w_bit_end) begin
      w_baud_next = '0;
    end else begin
      w_baud_next = r_baud + CW'(1);
    end
  end

  // Line level for the coming cycle, derived from the state being entered.
  always_comb begin
    w_txd_next = 1'b1;
    case (w_state_next)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = r_shift[w_bit_idx_next];
      default: w_txd_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench: writes push expected bytes; a line monitor decodes each
// frame cycle by cycle and compares against the queue head.
module tb_uart_tx_buffered;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [2:0] count;
  logic       TxD;
  logic       TxD_busy;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];

  uart_tx_buffered #(
    .CLK_FREQ   (1000),
    .BAUD       (100),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .count    (count),
    .TxD      (TxD),
    .TxD_busy (TxD_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d, input bit expect_tx);
    wr_en   = 1'b1;
    wr_data = d;
    if (expect_tx) exp_q.push_back(d);
    tick;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget, output int fell_at);
    int n;
    n = 0;
    while (TxD_busy !== 1'b0 && n < budget) begin
      tick;
      n++;
    end
    fell_at = cyc;
    checks++;
    if (TxD_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: TxD_busy still %b after %0d cycles", name, TxD_busy, budget);
    end
  endtask

  // Line monitor: on each start bit, pop the expected byte and check every cycle.
  initial begin
    logic [7:0] expb;
    logic [7:0] got;
    logic       lvl;
    int         bad;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || TxD !== 1'b0) continue;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: start bit at cycle %0d with empty scoreboard", cyc);
        expb = 8'h00;
      end else begin
        expb = exp_q.pop_front();
      end
      bad     = 0;
      got     = 8'h00;
      aborted = 1'b0;
      for (int k = 0; k < 10 * DIV; k++) begin
        if (k > 0) @(negedge clk);
        if (reset !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        if (k < DIV) lvl = 1'b0;
        else if (k >= 9 * DIV) lvl = 1'b1;
        else lvl = expb[k / DIV - 1];
        if (TxD !== lvl) bad++;
        if (k >= DIV && k < 9 * DIV && (k % DIV) == DIV / 2) got[k / DIV - 1] = TxD;
      end
      if (!aborted) begin
        check("frame_bit_cycles_wrong", bad, 0);
        check("frame_byte", got, expb);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int fell;
    int bad;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tick;
    tick;
    check("reset_state", {TxD, TxD_busy, full, count}, 6'b100000);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      tick;
      check("idle_state", {TxD, TxD_busy, full, count}, 6'b100000);
    end

    // Single byte: latency and frame length
    write_byte(8'hA5, 1'b1);
    e0 = cyc;
    check("count_after_write", count, 1);
    tick;
    check("start_latency_txd", TxD, 0);
    check("count_after_pop", count, 0);
    wait_idle("a5_idle", 200, fell);
    check("a5_busy_fall_cycle", fell - e0, 101);

    // Three back-to-back frames
    write_byte(8'h01, 1'b1);
    e0 = cyc;
    write_byte(8'h02, 1'b1);
    write_byte(8'h03, 1'b1);
    check("count_after_burst", count, 2);
    wait_idle("burst_idle", 400, fell);
    check("burst_span_cycles", fell - (e0 + 1), 300);

    // Fill while in flight, drop on full, then push on a pop edge
    write_byte(8'h11, 1'b1);
    e0 = cyc;
    tick;
    write_byte(8'h22, 1'b1);
    write_byte(8'h33, 1'b1);
    write_byte(8'h44, 1'b1);
    write_byte(8'h55, 1'b1);
    check("fill_count", count, 4);
    check("fill_full", full, 1);
    write_byte(8'hFF, 1'b0);
    check("drop_count", count, 4);
    check("drop_full", full, 1);
    while (cyc < e0 + 100) tick;
    check("pre_pop_full", full, 1);
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    exp_q.push_back(8'h3C);
    tick;
    wr_en = 1'b0;
    check("push_pop_count", count, 4);
    check("push_pop_full", full, 1);
    check("push_pop_next_start", TxD, 0);
    wait_idle("full_idle", 700, fell);
    check("scoreboard_drained", exp_q.size(), 0);

    // Reset mid-frame discards everything
    write_byte(8'hAA, 1'b1);
    e0 = cyc;
    write_byte(8'hBB, 1'b0);
    write_byte(8'hCC, 1'b0);
    while (cyc < e0 + 35) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_state", {TxD, TxD_busy, full, count}, 6'b100000);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (TxD !== 1'b1 || TxD_busy !== 1'b0) bad++;
    end
    check("post_reset_quiet_cycles_bad", bad, 0);
    check("post_reset_scoreboard", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
